// File: rtl/mc_controller_v2.sv
// mc_controller_v2 -- multicycle MIPS main control FSM with a variable-latency
// memory handshake, bus-error timeout and illegal-instruction reporting.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   op, funct         IR[31:26] and IR[5:0] of the current instruction
//   mem_ready         memory completes the outstanding mem_req this cycle
//   mem_req, MemWrite, MemMode            memory request / write strobe / access size
//   PCWrite, PCWriteCond, BranchNe, PCSource  PC update control
//   IorD, MemToReg, IRWrite, RegWrite, RegDst datapath steering and strobes
//   ALUSrcA, ALUSrcB, ALUOP               ALU operand select and operation
//   halted, illegal, bus_error            status (illegal/bus_error sticky as configured)
//   state_out                             current state encoding for debug
module mc_controller_v2 #(
    parameter int ALUOP_W         = 5,
    parameter int TIMEOUT         = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemWrite,
    output logic [2:0]         MemMode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic [1:0]         MemToReg,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               halted,
    output logic               illegal,
    output logic               bus_error,
    output logic [4:0]         state_out
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [4:0] {
        S_RESET     = 5'd0,  S_FETCH   = 5'd1,  S_DECODE   = 5'd2,
        S_MEM_ADDR  = 5'd3,  S_MEM_READ = 5'd4, S_MEM_WB   = 5'd5,
        S_MEM_WRITE = 5'd6,  S_RTYPE_EX = 5'd7, S_RTYPE_WB = 5'd8,
        S_IMM_EX    = 5'd9,  S_IMM_WB  = 5'd10, S_BRANCH   = 5'd11,
        S_JUMP      = 5'd12, S_JAL     = 5'd13, S_JR       = 5'd14,
        S_ILLEGAL   = 5'd15, S_HALT    = 5'd16
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDIU = 6'b001001,
                           OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110,
                           OP_LUI   = 6'b001111, OP_LB   = 6'b100000, OP_LH   = 6'b100001,
                           OP_LW    = 6'b100011, OP_LBU  = 6'b100100, OP_LHU  = 6'b100101,
                           OP_SB    = 6'b101000, OP_SH   = 6'b101001, OP_SW   = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011,
                           F_JR  = 6'b001000, F_SYSCALL = 6'b001100,
                           F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010,
                           F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR  = 6'b100101,
                           F_XOR = 6'b100110, F_SLT  = 6'b101010;

    localparam logic [4:0] A_ADD = 5'b00000, A_OR  = 5'b00001, A_AND  = 5'b00010,
                           A_XOR = 5'b00011, A_SLL = 5'b00100, A_SRL  = 5'b00101,
                           A_SRA = 5'b00110, A_LUI = 5'b00111, A_ORI  = 5'b01000,
                           A_SUB = 5'b01001, A_SLT = 5'b01010, A_ANDI = 5'b01011,
                           A_XORI = 5'b01100;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             illegal_reg, illegal_next;
    logic             bus_error_reg, bus_error_next;

    logic             is_load, is_store, is_imm, rtype_alu, is_shift;
    logic [2:0]       mode_op;
    logic [4:0]       rtype_aluop, imm_aluop, aluop_c;
    logic             mem_phase, timeout_hit;

    // Instruction classification shared by DECODE and the execute states.
    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        mode_op     = 3'b000;
        is_imm      = 1'b0;
        imm_aluop   = A_ADD;
        rtype_alu   = 1'b1;
        is_shift    = 1'b0;
        rtype_aluop = A_ADD;
        case (op)
            OP_LW:    is_load = 1'b1;
            OP_LB:    begin is_load = 1'b1; mode_op = 3'b001; end
            OP_LBU:   begin is_load = 1'b1; mode_op = 3'b010; end
            OP_LH:    begin is_load = 1'b1; mode_op = 3'b011; end
            OP_LHU:   begin is_load = 1'b1; mode_op = 3'b100; end
            OP_SW:    is_store = 1'b1;
            OP_SB:    begin is_store = 1'b1; mode_op = 3'b001; end
            OP_SH:    begin is_store = 1'b1; mode_op = 3'b011; end
            OP_ORI:   begin is_imm = 1'b1; imm_aluop = A_ORI;  end
            OP_ANDI:  begin is_imm = 1'b1; imm_aluop = A_ANDI; end
            OP_XORI:  begin is_imm = 1'b1; imm_aluop = A_XORI; end
            OP_LUI:   begin is_imm = 1'b1; imm_aluop = A_LUI;  end
            OP_ADDIU: is_imm = 1'b1;
            default:  ;
        endcase
        case (funct)
            F_ADD, F_ADDU: rtype_aluop = A_ADD;
            F_SUB, F_SUBU: rtype_aluop = A_SUB;
            F_AND:         rtype_aluop = A_AND;
            F_OR:          rtype_aluop = A_OR;
            F_XOR:         rtype_aluop = A_XOR;
            F_SLT:         rtype_aluop = A_SLT;
            F_SLL:         begin rtype_aluop = A_SLL; is_shift = 1'b1; end
            F_SRL:         begin rtype_aluop = A_SRL; is_shift = 1'b1; end
            F_SRA:         begin rtype_aluop = A_SRA; is_shift = 1'b1; end
            default:       rtype_alu = 1'b0;
        endcase
    end

    // The timeout fires in the cycle the counter already holds TIMEOUT and
    // memory is still not ready; a ready in that same cycle completes normally.
    assign mem_phase   = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                         (state_reg == S_MEM_WRITE);
    assign timeout_hit = (TIMEOUT != 0) && mem_phase && !mem_ready &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT));

    always_comb begin
        state_next     = state_reg;
        illegal_next   = illegal_reg;
        bus_error_next = bus_error_reg;
        mem_req     = 1'b0;  MemWrite    = 1'b0;  MemMode  = 3'b000;
        PCWrite     = 1'b0;  PCWriteCond = 1'b0;  BranchNe = 1'b0;
        PCSource    = 2'b00; IorD        = 1'b0;  MemToReg = 2'b00;
        IRWrite     = 1'b0;  RegWrite    = 1'b0;  RegDst   = 2'b00;
        ALUSrcA     = 2'b00; ALUSrcB     = 2'b00; aluop_c  = A_ADD;

        if (timeout_hit) begin
            bus_error_next = 1'b1;
            state_next     = S_HALT;
        end else begin
            case (state_reg)
                S_RESET: state_next = S_FETCH;
                S_FETCH: begin
                    mem_req = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        PCWrite    = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    if (is_load || is_store)                      state_next = S_MEM_ADDR;
                    else if (is_imm)                              state_next = S_IMM_EX;
                    else if (op == OP_BEQ || op == OP_BNE)        state_next = S_BRANCH;
                    else if (op == OP_J)                          state_next = S_JUMP;
                    else if (op == OP_JAL)                        state_next = S_JAL;
                    else if (op == OP_RTYPE && funct == F_JR)     state_next = S_JR;
                    else if (op == OP_RTYPE && funct == F_SYSCALL) state_next = S_HALT;
                    else if (op == OP_RTYPE && rtype_alu)         state_next = S_RTYPE_EX;
                    else                                          state_next = S_ILLEGAL;
                end
                S_MEM_ADDR: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    state_next = is_load ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    MemMode = mode_op;
                    if (mem_ready) state_next = S_MEM_WB;
                end
                S_MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemToReg   = 2'b01;
                    MemMode    = mode_op;
                    state_next = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    MemMode  = mode_op;
                    if (mem_ready) state_next = S_FETCH;
                end
                S_RTYPE_EX: begin
                    ALUSrcA    = is_shift ? 2'b10 : 2'b01;
                    aluop_c    = rtype_aluop;
                    state_next = S_RTYPE_WB;
                end
                S_RTYPE_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 2'b01;
                    state_next = S_FETCH;
                end
                S_IMM_EX: begin
                    ALUSrcA    = 2'b01;
                    ALUSrcB    = 2'b10;
                    aluop_c    = imm_aluop;
                    state_next = S_IMM_WB;
                end
                S_IMM_WB: begin
                    RegWrite   = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA     = 2'b01;
                    aluop_c     = A_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    BranchNe    = (op == OP_BNE);
                    state_next  = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    state_next = S_FETCH;
                end
                S_JAL: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    RegWrite   = 1'b1;
                    RegDst     = 2'b10;
                    MemToReg   = 2'b10;
                    state_next = S_FETCH;
                end
                S_JR: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b11;
                    state_next = S_FETCH;
                end
                S_ILLEGAL: begin
                    if (HALT_ON_ILLEGAL) begin
                        illegal_next = 1'b1;
                        state_next   = S_HALT;
                    end else begin
                        state_next   = S_FETCH;
                    end
                end
                S_HALT:  state_next = S_HALT;
                default: state_next = S_RESET;
            endcase
        end

        // Count stalled request cycles; any completion or state change restarts it.
        if (mem_ready || state_next != state_reg)
            wait_cnt_next = '0;
        else if (mem_req && TIMEOUT != 0)
            wait_cnt_next = wait_cnt_reg + 1'b1;
        else
            wait_cnt_next = wait_cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_RESET;
            wait_cnt_reg  <= '0;
            illegal_reg   <= 1'b0;
            bus_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            illegal_reg   <= illegal_next;
            bus_error_reg <= bus_error_next;
        end
    end

    assign ALUOP     = ALUOP_W'(aluop_c);
    assign halted    = (state_reg == S_HALT);
    // The ILLEGAL state itself drives the flag, giving a pulse when not halting.
    assign illegal   = illegal_reg || (state_reg == S_ILLEGAL);
    assign bus_error = bus_error_reg;
    assign state_out = state_reg;

endmodule
